// File: rtl/memory_reader.sv
// memory_reader: streams a burst of words from a synchronous-read memory
// to a valid/ready sink. One word every three cycles (REQ, WAIT, OUT).
// All outputs are registered and are derived from the next state.
module memory_reader #(
  parameter int DATA_W = 35,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rden_q, rden_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // abort together with start in IDLE suppresses the start
          if (start && !abort) begin
            if (count != '0) begin
              ptr_d   = base_addr;
              rem_d   = count;
              state_d = S_REQ;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_REQ:  state_d = S_WAIT;
        S_WAIT: begin
          data_d  = mem_rdata;
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          state_d = S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            state_d = (rem_q != '0) ? S_REQ : S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // Outputs follow the state being entered so they are glitch-free flops.
    rden_d  = (state_d == S_REQ);
    addr_d  = (state_d == S_REQ) ? ptr_d : addr_q;
    valid_d = (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rden_q  <= rden_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_rden  = rden_q;
  assign mem_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_memory_reader.sv
// Testbench for memory_reader: table of bursts with per-cycle timing checks,
// plus hand-written stall, abort and asynchronous-reset sequences.
module tb_memory_reader;

  localparam int DATA_W = 35;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              abort = 1'b0;
  logic              mem_rden;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  memory_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .arst(arst), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: mem[i] = i + 100, data valid the cycle after mem_rden.
  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= DATA_W'(mem_addr) + DATA_W'(100);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   cnt;
    logic [63:0]       first;
    logic [63:0]       last;
    int                done_cyc;
  } vec_t;

  // Burst with out_ready high; k counts cycles after the start edge.
  task automatic run_burst(input vec_t v);
    int n;
    n = int'(v.cnt);
    @(negedge clk);
    start = 1'b1; base_addr = v.base; count = v.cnt;
    @(negedge clk);
    start = 1'b0; base_addr = '0; count = '0;
    for (int k = 1; k <= v.done_cyc + 1; k++) begin
      chk("rden", mem_rden, (n > 0 && (k % 3) == 1 && k < 3 * n));
      chk("valid", out_valid, (n > 0 && (k % 3) == 0 && k <= 3 * n));
      chk("done", done, (k == v.done_cyc));
      chk("busy", busy, (k <= v.done_cyc));
      if (n > 0 && (k % 3) == 1 && k < 3 * n)
        chk("addr", mem_addr, (v.base + (k - 1) / 3) & 15);
      if (n > 0 && (k % 3) == 0 && k <= 3 * n) begin
        if (k == 3)           chk("data_first", out_data, v.first);
        else if (k == 3 * n)  chk("data_last", out_data, v.last);
        else                  chk("data_mid", out_data, ((v.base + k / 3 - 1) & 15) + 100);
      end
      if (n > 0 && k == v.done_cyc)
        chk("addr_hold", mem_addr, (v.base + n - 1) & 15);
      @(negedge clk);
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{base: 4'd3,  cnt: 5'd3, first: 103, last: 105, done_cyc: 10};
    vecs[1] = '{base: 4'd15, cnt: 5'd2, first: 115, last: 100, done_cyc: 7};
    vecs[2] = '{base: 4'd0,  cnt: 5'd1, first: 100, last: 100, done_cyc: 4};
    vecs[3] = '{base: 4'd14, cnt: 5'd4, first: 114, last: 101, done_cyc: 13};
    vecs[4] = '{base: 4'd5,  cnt: 5'd0, first: 0,   last: 0,   done_cyc: 1};

    // Reset state
    #12;
    chk("rst_rden", mem_rden, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // Backpressure: data held, no new read until handshake
    out_ready = 1'b0;
    start = 1'b1; base_addr = 4'd2; count = 5'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 102);
      chk("stall_rden", mem_rden, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("stall_valid_last", out_valid, 1);
    @(negedge clk);
    chk("stall_rden2", mem_rden, 1);
    chk("stall_addr2", mem_addr, 3);
    chk("stall_valid_drop", out_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_valid2", out_valid, 1);
    chk("stall_data2", out_data, 103);
    @(negedge clk);
    chk("stall_done", done, 1);
    @(negedge clk);

    // Abort in second OUT; start pulsed mid-burst is ignored
    start = 1'b1; base_addr = 4'd0; count = 5'd4;
    @(negedge clk); start = 1'b0;                   // k=1 REQ
    @(negedge clk);                                 // k=2 WAIT
    start = 1'b1; base_addr = 4'd9; count = 5'd1;
    @(negedge clk); start = 1'b0; base_addr = '0; count = '0; // k=3 OUT
    chk("ab_data1", out_data, 100);
    @(negedge clk);                                 // k=4 REQ
    chk("ab_ign_addr", mem_addr, 1);
    chk("ab_ign_rden", mem_rden, 1);
    @(negedge clk);
    @(negedge clk);                                 // k=6 OUT
    chk("ab_valid2", out_valid, 1);
    chk("ab_data2", out_data, 101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_valid", out_valid, 0);
    chk("ab_rden", mem_rden, 0);
    chk("ab_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ab_idle_busy", busy, 0);
      chk("ab_idle_done", done, 0);
    end

    // abort with start in IDLE: start ignored
    start = 1'b1; abort = 1'b1; base_addr = 4'd1; count = 5'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("ab_idle_start_busy", busy, 0);
    chk("ab_idle_start_rden", mem_rden, 0);
    chk("ab_idle_start_done", done, 0);
    @(negedge clk);

    // Asynchronous reset mid-WAIT
    start = 1'b1; base_addr = 4'd7; count = 5'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);                                 // WAIT
    chk("ar_busy_before", busy, 1);
    chk("ar_addr_before", mem_addr, 7);
    #2 arst = 1'b1;
    #1;
    chk("ar_rden", mem_rden, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_data", out_data, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("ar_idle_busy", busy, 0);
    run_burst('{base: 4'd8, cnt: 5'd1, first: 108, last: 108, done_cyc: 4});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_reader.md
MEMORY_READER -- requirements
Module: memory_reader

Interface
REQ-001 Parameter DATA_W, default 35; width of memory word and output data.
REQ-002 Parameter ADDR_W, default 4; memory address width, depth 2^ADDR_W words.
REQ-003 clk  input  1  clock, all state updates on posedge.
REQ-004 arst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  burst request, sampled on posedge in IDLE only.
REQ-006 base_addr  input  ADDR_W  first word address, sampled with start.
REQ-007 count  input  ADDR_W+1  words to read (0..2^ADDR_W), sampled with start.
REQ-008 abort  input  1  terminate burst, sampled every posedge.
REQ-009 mem_rden  output  1  memory read strobe.
REQ-010 mem_addr  output  ADDR_W  memory read address.
REQ-011 mem_rdata  input  DATA_W  memory data, valid exactly one cycle after mem_rden.
REQ-012 out_data  output  DATA_W  streamed word.
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  downstream accepts word when high with out_valid.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal burst completion.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, OUT, DONE; all outputs registered.
REQ-018 IDLE: start=1 and count>0 -> latch base_addr into addr pointer, count into remaining counter, go REQ; start=1 and count=0 -> go DONE, no memory access.
REQ-019 REQ: mem_rden=1, mem_addr=pointer, for exactly one cycle; next state WAIT.
REQ-020 WAIT: capture mem_rdata into out_data register at end of cycle; increment pointer modulo 2^ADDR_W; decrement remaining; next state OUT.
REQ-021 OUT: out_valid=1, out_data stable until handshake; on out_valid&out_ready -> REQ if remaining>0, else DONE.
REQ-022 DONE: done=1 for one cycle, busy=1; next state IDLE.
REQ-023 Latency: start sampled on edge N -> mem_rden high in cycle N+1 -> out_valid high in cycle N+3.
REQ-024 Throughput: with out_ready held high, one word per 3 cycles.
REQ-025 Address wrap: pointer at 2^ADDR_W-1 SHALL increment to 0.
REQ-026 start while busy SHALL be ignored; no state change and no latch of base_addr/count.
REQ-027 mem_rden SHALL be 0 and mem_addr SHALL hold last value outside REQ.
REQ-028 abort=1 in any non-IDLE state: next state IDLE, out_valid=0, mem_rden=0, no done pulse; abort has priority over handshake and start.
REQ-029 abort in IDLE SHALL have no effect; abort and start together in IDLE: start ignored.
REQ-030 out_valid SHALL not drop without handshake, except on abort or arst.

Reset
REQ-031 arst SHALL force state IDLE immediately, independent of clk.
REQ-032 Reset values: mem_rden=0, mem_addr=0, out_data=0, out_valid=0, busy=0, done=0, pointer=0, remaining=0.
REQ-033 arst mid-burst SHALL discard remaining words; first start after release behaves as REQ-018.

Verification
REQ-034 base_addr=3, count=3, memory[i]=i+100, out_ready=1 -> out_data 103,104,105 at cycles N+3,N+6,N+9; done pulse at N+10.
REQ-035 base_addr=15, count=2 -> mem_addr 15 then 0; outputs memory[15], memory[0].
REQ-036 count=0 with start -> done pulse cycle N+1, mem_rden never asserted, out_valid stays 0.
REQ-037 count=2, out_ready=0 for 5 cycles after first out_valid -> out_data held constant, no second mem_rden until handshake.
REQ-038 count=4, abort asserted in second OUT -> IDLE next cycle, out_valid=0, no done; start pulsed during burst ignored.
REQ-039 arst asserted mid-WAIT -> all outputs 0 asynchronously; new burst after release yields correct data.
